convolution_3x3: RTL and testbench



---
 rtl/convolution_3x3.sv | 88 ++++++++
 tb/tb_convolution_3x3.sv | 107 ++++++++++
 2 files changed

// File: rtl/convolution_3x3.sv
// convolution_3x3: streaming 3x3 Gaussian smoothing filter.
//   One raster-ordered pixel in, one filtered pixel out, every clock.
//   There is no handshake, no enable and no border handling. Rows wrap into
//   their neighbours, and the first rows see zeros left by reset.
// Ports:
//   clk         - single clock, rising edge
//   rst         - asynchronous reset, active low; clears every flop
//   inputPixel  - incoming pixel, sampled on every rising edge
//   outputPixel - registered filtered pixel (weighted sum >> 4)
module convolution_3x3 #(
  parameter int WORD_SIZE = 8,
  parameter int ROW_SIZE  = 540
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] inputPixel,
  output logic [WORD_SIZE-1:0] outputPixel
);
  localparam int PW = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
  localparam int SW = WORD_SIZE + 4;

  typedef logic [WORD_SIZE-1:0] pix_t;

  // Window layout is [row][col]. Row 0 is the oldest row (top) and col 2 is
  // the newest sample in each row.
  pix_t win_q [3][3];
  pix_t win_d [3][3];

  // Both line buffers share one column pointer. Each location is read before
  // it is written in the same cycle, so a read returns the word stored
  // ROW_SIZE edges earlier.
  pix_t lb_mid_q [ROW_SIZE];
  pix_t lb_mid_d [ROW_SIZE];
  pix_t lb_top_q [ROW_SIZE];
  pix_t lb_top_d [ROW_SIZE];

  logic [PW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] sum;
  pix_t          out_q, out_d;

  always_comb begin
    win_d    = win_q;
    lb_mid_d = lb_mid_q;
    lb_top_d = lb_top_q;
    for (int r = 0; r < 3; r++) begin
      win_d[r][0] = win_q[r][1];
      win_d[r][1] = win_q[r][2];
    end
    win_d[2][2] = inputPixel;         // x[n]
    win_d[1][2] = lb_mid_q[ptr_q];    // x[n-R]
    win_d[0][2] = lb_top_q[ptr_q];    // x[n-2R]
    lb_mid_d[ptr_q] = inputPixel;
    lb_top_d[ptr_q] = lb_mid_q[ptr_q];
    ptr_d = (ptr_q == PW'(ROW_SIZE - 1)) ? '0 : ptr_q + 1'b1;
  end

  // Kernel weights are 1 << ((r==1)+(c==1)), which gives 1 2 1 / 2 4 2 / 1 2 1.
  // The largest sum is 16*(2^W-1), so it fits in W+4 bits without overflow.
  always_comb begin
    sum = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        sum = sum + (SW'(win_q[r][c]) << (int'(r == 1) + int'(c == 1)));
    out_d = WORD_SIZE'(sum >> 4);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_q[r][c] <= '0;
      for (int i = 0; i < ROW_SIZE; i++) begin
        lb_mid_q[i] <= '0;
        lb_top_q[i] <= '0;
      end
      ptr_q <= '0;
      out_q <= '0;
    end else begin
      win_q    <= win_d;
      lb_mid_q <= lb_mid_d;
      lb_top_q <= lb_top_d;
      ptr_q    <= ptr_d;
      out_q    <= out_d;
    end
  end

  assign outputPixel = out_q;
endmodule

// File: tb/tb_convolution_3x3.sv
// Directed bench for convolution_3x3 with ROW_SIZE=4. Inputs change 1ns after
// a rising edge and outputs are sampled there, so the k-th step observes the
// output after edge k.
module tb_convolution_3x3;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_px = '0;
  logic [7:0] out_px;
  int         checks = 0;
  int         passed = 0;

  convolution_3x3 #(.WORD_SIZE(8), .ROW_SIZE(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .inputPixel (in_px),
    .outputPixel(out_px)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step(input logic [7:0] px);
    in_px = px;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_px = '0;
    rst   = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Output after edge k, taken from hand-worked window sums
  logic [7:0] imp_exp [14] = '{8'h00, 8'h0F, 8'h1F, 8'h0F, 8'h00, 8'h1F, 8'h3F,
                               8'h1F, 8'h00, 8'h0F, 8'h1F, 8'h0F, 8'h00, 8'h00};
  logic [7:0] c40_exp [16] = '{8'h00, 8'h04, 8'h0C, 8'h10, 8'h10, 8'h18, 8'h28, 8'h30,
                               8'h30, 8'h34, 8'h3C, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40};
  logic [7:0] cff_exp [16] = '{8'h00, 8'h0F, 8'h2F, 8'h3F, 8'h3F, 8'h5F, 8'h9F, 8'hBF,
                               8'hBF, 8'hCF, 8'hEF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

  initial begin
    // Reset state
    #2;
    chk("reset_state", out_px, 8'h00);
    do_reset();

    // Impulse at x[0]
    for (int k = 0; k < 14; k++) begin
      step((k == 0) ? 8'hFF : 8'h00);
      chk($sformatf("impulse_e%0d", k), out_px, imp_exp[k]);
    end

    // Constant 0x40 ramp and settle
    do_reset();
    for (int k = 0; k < 16; k++) begin
      step(8'h40);
      chk($sformatf("const40_e%0d", k), out_px, c40_exp[k]);
    end

    // Full scale 0xFF, maximum sum 4080
    do_reset();
    for (int k = 0; k < 16; k++) begin
      step(8'hFF);
      chk($sformatf("full_e%0d", k), out_px, cff_exp[k]);
    end

    // Asynchronous reset mid-stream with a full window
    #2;
    in_px = 8'hAA;
    rst   = 1'b0;
    #1;
    chk("async_reset_now", out_px, 8'h00);
    @(posedge clk);
    #1;
    chk("async_reset_held", out_px, 8'h00);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(8'h00);
      chk($sformatf("post_reset_e%0d", k), out_px, 8'h00);
    end

    // Alternating 0x00 / 0x80 rows. The row above and the row below each
    // centre always hold the opposite value, so every steady window sums to 1024.
    do_reset();
    for (int k = 0; k < 40; k++) begin
      step(((k / 4) % 2 == 1) ? 8'h80 : 8'h00);
      if (k >= 11) chk($sformatf("rowwrap_e%0d", k), out_px, 8'h40);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end
endmodule
